// File: rtl/datapath_unit.sv
// datapath_unit: accumulator datapath for a small phased CPU.
// Holds the PC, the IR, the A/B registers, an OUT register with a valid/ready
// handshake, a sticky overrun flag and a sticky halt flag.
// Optional feature: define ALU_FLAGS_EN to build the CARRY/ZERO flag logic.
// Without it, both flags are tied to 0.
module datapath_unit (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_phase,
    input  logic       i_loada,
    input  logic       i_loadb,
    input  logic       i_enablealu,
    input  logic       i_enableinstr,
    input  logic       i_addsub,
    output logic [3:0] o_instr,
    output logic [3:0] o_mem_addr,
    input  logic [7:0] i_mem_data,
    output logic [7:0] o_acc,
    output logic [7:0] o_out_data,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic       o_overrun,
    output logic       o_halt,
    output logic       o_carry,
    output logic       o_zero
);

    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [3:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_out_data;
    logic       r_out_valid;
    logic       r_overrun;
    logic       r_halt;

    logic [1:0] w_phase;
    logic       w_fetch;
    logic       w_exec;
    logic       w_op_out;
    logic       w_op_hlt;
    logic       w_alu_wr;
    logic       w_out_take;
    logic       w_out_drain;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [8:0] w_alu;
    logic       w_unused;

    // Only PHASE[1:0] is meaningful.
    assign w_phase  = i_phase[1:0];
    assign w_fetch  = (w_phase == 2'd0) && !r_halt;
    assign w_exec   = (w_phase == 2'd2);
    assign w_op_out = w_exec && (r_ir[7:4] == OP_OUT) && !r_halt;
    assign w_op_hlt = w_exec && (r_ir[7:4] == OP_HLT);
    assign w_alu_wr = i_loada && i_enablealu && !r_halt;

    // A nine-bit subtraction puts the borrow in bit 8, in the same place as
    // the carry-out of the addition.
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};
    assign w_alu  = i_addsub ? w_diff : w_sum;

    // A new OUT is accepted into an empty register, or into one that is
    // draining at this same edge.
    assign w_out_take  = w_op_out && (!r_out_valid || i_out_ready);
    assign w_out_drain = r_out_valid && i_out_ready;

    // ENABLEINSTR is not used here: PHASE alone sequences the fetch.
    assign w_unused = ^{i_enableinstr, i_phase[2], w_alu[8]};

    assign o_instr     = r_ir[7:4];
    assign o_mem_addr  = w_phase[1] ? r_ir[3:0] : r_pc;
    assign o_acc       = r_a;
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_overrun   = r_overrun;
    assign o_halt      = r_halt;

    // Fetch: latch the instruction and advance the PC (it wraps at 15).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= '0;
            r_ir <= '0;
        end else if (w_fetch) begin
            r_ir <= i_mem_data;
            r_pc <= r_pc + 4'd1;
        end
    end

    // Register B loads from memory; frozen while halted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_b <= '0;
        end else if (i_loadb && !r_halt) begin
            r_b <= i_mem_data;
        end
    end

    // Accumulator: ALU result or a direct memory load. The ALU reads B from
    // before this edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a <= '0;
        end else if (i_loada && !r_halt) begin
            if (i_enablealu) begin
                r_a <= w_alu[7:0];
            end else begin
                r_a <= i_mem_data;
            end
        end
    end

    // Output register and handshake, with the sticky overrun flag for an OUT
    // that arrives while the register is still full.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_out_take) begin
                r_out_data  <= r_a;
                r_out_valid <= 1'b1;
            end else if (w_out_drain) begin
                r_out_valid <= 1'b0;
            end
            if (w_op_out && r_out_valid && !i_out_ready) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Sticky halt, set by the HLT opcode in the execute phase.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_halt <= 1'b0;
        end else if (w_op_hlt) begin
            r_halt <= 1'b1;
        end
    end

`ifdef ALU_FLAGS_EN
    logic r_carry;
    logic r_zero;

    // Flags update only when the ALU writes A; otherwise they hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_alu_wr) begin
            r_carry <= w_alu[8];
            r_zero  <= (w_alu[7:0] == 8'd0);
        end
    end

    assign o_carry = r_carry;
    assign o_zero  = r_zero;
`else
    logic w_unused_flags;

    assign w_unused_flags = w_alu_wr;
    assign o_carry        = 1'b0;
    assign o_zero         = 1'b0;
`endif

endmodule

// File: doc/datapath_unit.md
DATAPATH_UNIT -- requirements
Module: datapath_unit

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 RST  in  1  asynchronous active-high reset.
REQ-004 PHASE  in  3  control-unit phase, values 0..3; bit 2 ignored.
REQ-005 LOADA, LOADB, ENABLEALU, ENABLEINSTR, ADDSUB  in  1 each  control strobes from the control unit.
REQ-006 INSTR  out  4  current opcode, equal to IR[7:4], combinational from IR.
REQ-007 MEM_ADDR  out  4  program/data memory address, combinational.
REQ-008 MEM_DATA  in  8  memory read data, valid in the same cycle as MEM_ADDR.
REQ-009 ACC  out  8  accumulator A.
REQ-010 OUT_DATA  out  8  output register; OUT_VALID  out  1; OUT_READY  in  1; valid/ready handshake.
REQ-011 OVERRUN  out  1  sticky flag: output was lost; HALT  out  1  sticky halt status.
REQ-012 CARRY, ZERO  out  1 each  ALU flags (see Configuration).

Function
REQ-013 Instruction word is 8 bits: [7:4] opcode, [3:0] operand address.
REQ-014 MEM_ADDR SHALL be PC when PHASE is 0 or 1, and IR[3:0] when PHASE is 2 or 3.
REQ-015 Fetch: at a rising edge with PHASE==0 and HALT==0, IR<=MEM_DATA and PC<=PC+1; PC wraps 15->0.
REQ-016 LOADB==1: B<=MEM_DATA.
REQ-017 LOADA==1 and ENABLEALU==1: A<=A+B when ADDSUB==0, A<=A-B when ADDSUB==1; arithmetic is mod 256.
REQ-018 LOADA==1 and ENABLEALU==0: A<=MEM_DATA (load-immediate from memory).
REQ-019 LOADA and LOADB both high: both updates occur in the same edge; the ALU uses pre-edge B.
REQ-020 ENABLEALU without LOADA SHALL change no state.
REQ-021 Opcode 4'b1110 (OUT), decoded locally: at the PHASE==2 edge, if OUT_VALID==0, OUT_DATA<=A and OUT_VALID<=1.
REQ-022 OUT_VALID clears at an edge where OUT_VALID&&OUT_READY, unless a new OUT is captured at that same edge, in which case OUT_DATA takes the new A and OUT_VALID stays 1.
REQ-023 OUT at PHASE==2 while OUT_VALID==1 and OUT_READY==0: the new value is dropped, OUT_DATA is held, and OVERRUN<=1 (sticky).
REQ-024 Opcode 4'b1111 (HLT): at the PHASE==2 edge, HALT<=1; while HALT==1, PC, IR, A, B and flags are frozen, and the output handshake still completes.
REQ-025 Opcodes other than 1110/1111 SHALL have no local effect; their behaviour is driven only by the strobes.

Reset
REQ-026 RST high SHALL asynchronously force PC=0, IR=0, A=0, B=0, OUT_DATA=0, OUT_VALID=0, OVERRUN=0, HALT=0, CARRY=0, ZERO=0.
REQ-027 Reset during an OUT transfer SHALL abandon that transfer; OUT_VALID is 0 in the first cycle after release.

Configuration
REQ-028 Macro ALU_FLAGS_EN defined: on each ALU write (REQ-017), CARRY<=carry-out (add) or borrow (sub), and ZERO<=(result==0); otherwise the flags hold.
REQ-029 ALU_FLAGS_EN undefined: CARRY and ZERO are constant 0 and no flag logic is present.

Verification
REQ-030 Memory {0:0x59, 1:0x1A, 2:0xE0, 3:0xF0, 9:0x05, A:0x03} with a standard CU strobe sequence -> A=0x08, OUT_DATA=0x08, OUT_VALID=1, HALT=1, PC frozen at 4.
REQ-031 A=0x03, B=0x05, SUB -> A=0xFE; with ALU_FLAGS_EN: CARRY=1, ZERO=0. A=0x05, B=0x05, SUB -> ZERO=1.
REQ-032 OUT_READY=0 and two OUT instructions with A=0x11 then A=0x22 -> OUT_DATA=0x11, OVERRUN=1.
REQ-033 OUT_VALID=1 and OUT_READY=1 at the same edge as a new OUT with A=0x33 -> OUT_DATA=0x33, OUT_VALID=1, OVERRUN=0.
REQ-034 16 fetches from reset -> PC wraps to 0.
REQ-035 RST asserted mid-cycle with PHASE==3 -> all outputs 0 immediately, before the next clock edge.
